// File: rtl/bridge_sram_arbiter_if.sv
// Bridge, core and SRAM-pin bundle for bridge_sram_arbiter.
// The arbiter takes the slave view; the environment (bridge decoder, core, pins) takes master.
interface bridge_sram_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic [31:0]       bridge_addr;
    logic              bridge_wr;
    logic [31:0]       bridge_wr_data;
    logic              bridge_rd;
    logic [31:0]       bridge_rd_data;
    logic              bridge_rd_valid;
    logic              bridge_ready;
    logic              err_drop;
    logic              core_req;
    logic [ADDR_W-1:0] core_addr;
    logic              core_ack;
    logic [15:0]       core_rd_data;
    logic [ADDR_W-1:0] sram_a;
    logic [15:0]       sram_dq_out;
    logic              sram_dq_oe;
    logic [15:0]       sram_dq_in;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_ub_n;
    logic              sram_lb_n;

    modport slave (
        input  bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
        output bridge_rd_data, bridge_rd_valid, bridge_ready, err_drop,
        input  core_req, core_addr,
        output core_ack, core_rd_data,
        output sram_a, sram_dq_out, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        input  sram_dq_in
    );

    modport master (
        output bridge_addr, bridge_wr, bridge_wr_data, bridge_rd,
        input  bridge_rd_data, bridge_rd_valid, bridge_ready, err_drop,
        output core_req, core_addr,
        input  core_ack, core_rd_data,
        input  sram_a, sram_dq_out, sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n,
        output sram_dq_in
    );
endinterface

// File: rtl/bridge_sram_arbiter.sv
// Shares a x16 async SRAM between 32-bit bridge accesses (two 16-bit phases) and a core read port.
// Optional macro SRAM_ARB_FAIR_EN: alternate core/bridge grants instead of strict bridge priority.
module bridge_sram_arbiter #(
    parameter int ACCESS_CYCLES = 2,
    parameter int ADDR_W        = 16
) (
    input  logic                  clk_74a,
    input  logic                  reset_n,
    bridge_sram_arbiter_if.slave  bus
);
    localparam int CW = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(ACCESS_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_BR_HI = 2'd1;
    localparam logic [1:0] S_BR_LO = 2'd2;
    localparam logic [1:0] S_CORE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              pend_q;
    logic              is_wr_q;
    logic [ADDR_W-2:0] waddr_q;
    logic [31:0]       wdata_q;
    logic              last_br_q;
    logic [ADDR_W-1:0] core_addr_q;
    logic [31:0]       rd_data_q;
    logic              rd_valid_q;
    logic              core_ack_q;
    logic [15:0]       core_rd_q;
    logic              err_q;

    logic cmd_any, accept, drop, br_req, core_first, last;
    logic unused_addr_bits;

    assign unused_addr_bits = ^{bus.bridge_addr[31:ADDR_W+1], bus.bridge_addr[1:0]};

    assign cmd_any = bus.bridge_wr | bus.bridge_rd;
    assign accept  = cmd_any & ~pend_q;
    assign drop    = (cmd_any & pend_q) | (bus.bridge_wr & bus.bridge_rd);
    // A pulse accepted in an IDLE cycle is granted immediately, not a cycle later.
    assign br_req  = pend_q | accept;
    assign last    = (cnt_q == LAST_CNT);

`ifdef SRAM_ARB_FAIR_EN
    assign core_first = bus.core_req & (last_br_q | ~br_req);
`else
    assign core_first = bus.core_req & ~br_req;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (core_first)  state_d = S_CORE;
                else if (br_req) state_d = S_BR_HI;
            end
            S_BR_HI: if (last) state_d = S_BR_LO;
            S_BR_LO: if (last) state_d = S_IDLE;
            default: if (last) state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            is_wr_q     <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            last_br_q   <= 1'b0;
            core_addr_q <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            core_ack_q  <= 1'b0;
            core_rd_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_q == S_IDLE || last) ? '0 : cnt_q + 1'b1;

            // Write wins a simultaneous wr/rd; the read is reported through err_drop.
            if (accept) begin
                pend_q  <= 1'b1;
                is_wr_q <= bus.bridge_wr;
                waddr_q <= bus.bridge_addr[ADDR_W:2];
                wdata_q <= bus.bridge_wr_data;
            end else if (state_q == S_BR_LO && last) begin
                pend_q  <= 1'b0;
            end
            if (drop) err_q <= 1'b1;

            if (state_q == S_IDLE && state_d == S_BR_HI) last_br_q <= 1'b1;
            if (state_q == S_IDLE && state_d == S_CORE) begin
                last_br_q   <= 1'b0;
                core_addr_q <= bus.core_addr;
            end

            if (state_q == S_BR_HI && last && !is_wr_q) rd_data_q[31:16] <= bus.sram_dq_in;
            if (state_q == S_BR_LO && last && !is_wr_q) rd_data_q[15:0]  <= bus.sram_dq_in;
            rd_valid_q <= (state_q == S_BR_LO) && last && !is_wr_q;

            if (state_q == S_CORE && last) core_rd_q <= bus.sram_dq_in;
            core_ack_q <= (state_q == S_CORE) && last;
        end
    end

    // Strobes decode straight from state so an async reset idles the pins in the same cycle.
    always_comb begin
        bus.sram_a      = '0;
        bus.sram_dq_out = '0;
        bus.sram_dq_oe  = 1'b0;
        bus.sram_oe_n   = 1'b1;
        bus.sram_we_n   = 1'b1;
        bus.sram_ub_n   = 1'b1;
        bus.sram_lb_n   = 1'b1;
        case (state_q)
            S_BR_HI, S_BR_LO: begin
                bus.sram_a      = {waddr_q, state_q == S_BR_LO};
                bus.sram_dq_out = (state_q == S_BR_HI) ? wdata_q[31:16] : wdata_q[15:0];
                bus.sram_ub_n   = 1'b0;
                bus.sram_lb_n   = 1'b0;
                if (is_wr_q) begin
                    bus.sram_dq_oe = 1'b1;
                    // Release we_n one cycle early for data hold; a 1-cycle phase strobes its only cycle.
                    bus.sram_we_n  = last && (ACCESS_CYCLES != 1);
                end else begin
                    bus.sram_oe_n  = 1'b0;
                end
            end
            S_CORE: begin
                bus.sram_a    = core_addr_q;
                bus.sram_oe_n = 1'b0;
                bus.sram_ub_n = 1'b0;
                bus.sram_lb_n = 1'b0;
            end
            default: ;
        endcase
    end

    assign bus.bridge_ready    = ~pend_q;
    assign bus.bridge_rd_data  = rd_data_q;
    assign bus.bridge_rd_valid = rd_valid_q;
    assign bus.err_drop        = err_q;
    assign bus.core_ack        = core_ack_q;
    assign bus.core_rd_data    = core_rd_q;
endmodule

// File: tb/tb_bridge_sram_arbiter.sv
// Directed bench for bridge_sram_arbiter (ACCESS_CYCLES=2) with a behavioural x16 SRAM.
module tb_bridge_sram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    bridge_sram_arbiter_if #(.ADDR_W(16)) bus ();

    bridge_sram_arbiter #(.ACCESS_CYCLES(2), .ADDR_W(16)) dut (
        .clk_74a (clk),
        .reset_n (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:65535];
    always @(posedge clk) if (!bus.sram_we_n && !bus.sram_lb_n) mem[bus.sram_a] <= bus.sram_dq_out;
    assign bus.sram_dq_in = mem[bus.sram_a];

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (!(bus.bridge_ready && bus.sram_ub_n) && n < 50) begin step(); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL %s timeout: not idle after %0d cycles", nm, n); end
    endtask

    task automatic bridge_pulse(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
        bus.bridge_wr = wr; bus.bridge_rd = rd; bus.bridge_addr = a; bus.bridge_wr_data = d;
        step();
        bus.bridge_wr = 1'b0; bus.bridge_rd = 1'b0;
    endtask

    task automatic test_reset();
        step(); step();
        total++; if (bus.bridge_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", bus.bridge_ready); end
        total++; if ({bus.err_drop, bus.bridge_rd_valid, bus.core_ack} !== 3'b000) begin bad++; $display("FAIL rst_pulses got %b want 000", {bus.err_drop, bus.bridge_rd_valid, bus.core_ack}); end
        total++; if ({bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe, bus.sram_ub_n, bus.sram_lb_n} !== 5'b11011) begin bad++; $display("FAIL rst_strobes got %b want 11011", {bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe, bus.sram_ub_n, bus.sram_lb_n}); end
        total++; if (bus.sram_a !== 16'h0) begin bad++; $display("FAIL rst_addr got %h want 0000", bus.sram_a); end
        total++; if ({bus.bridge_rd_data, bus.core_rd_data} !== 48'h0) begin bad++; $display("FAIL rst_rdata got %h want 0", {bus.bridge_rd_data, bus.core_rd_data}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write();
        bridge_pulse(1'b1, 1'b0, 32'h100, 32'hDEADBEEF);
        // cycle N+1: first cycle of the high phase
        total++; if ({bus.sram_a, bus.sram_dq_out} !== {16'h0080, 16'hDEAD}) begin bad++; $display("FAIL wr_hi_bus got %h/%h want 0080/DEAD", bus.sram_a, bus.sram_dq_out); end
        total++; if ({bus.sram_dq_oe, bus.sram_we_n, bus.bridge_ready} !== 3'b100) begin bad++; $display("FAIL wr_hi_c1 oe/we_n/rdy got %b want 100", {bus.sram_dq_oe, bus.sram_we_n, bus.bridge_ready}); end
        step();
        total++; if ({bus.sram_a, bus.sram_we_n, bus.sram_dq_oe} !== {16'h0080, 2'b11}) begin bad++; $display("FAIL wr_hi_c2 got %h/%b want 0080/11", bus.sram_a, {bus.sram_we_n, bus.sram_dq_oe}); end
        step();
        total++; if ({bus.sram_a, bus.sram_dq_out, bus.sram_we_n} !== {16'h0081, 16'hBEEF, 1'b0}) begin bad++; $display("FAIL wr_lo_c1 got %h/%h/%b want 0081/BEEF/0", bus.sram_a, bus.sram_dq_out, bus.sram_we_n); end
        step();
        total++; if (bus.sram_we_n !== 1'b1) begin bad++; $display("FAIL wr_lo_c2 we_n got %b want 1", bus.sram_we_n); end
        step();
        total++; if ({bus.bridge_ready, bus.sram_dq_oe, bus.bridge_rd_valid} !== 3'b100) begin bad++; $display("FAIL wr_done rdy/oe/vld got %b want 100", {bus.bridge_ready, bus.sram_dq_oe, bus.bridge_rd_valid}); end
        total++; if ({mem[16'h80], mem[16'h81]} !== 32'hDEADBEEF) begin bad++; $display("FAIL wr_mem got %h want DEADBEEF", {mem[16'h80], mem[16'h81]}); end
    endtask

    task automatic test_read();
        bridge_pulse(1'b0, 1'b1, 32'h100, 32'h0);
        total++; if ({bus.sram_a, bus.sram_oe_n, bus.sram_dq_oe} !== {16'h0080, 2'b00}) begin bad++; $display("FAIL rd_hi got %h/%b want 0080/00", bus.sram_a, {bus.sram_oe_n, bus.sram_dq_oe}); end
        step(); step(); step();
        total++; if (bus.bridge_rd_valid !== 1'b0) begin bad++; $display("FAIL rd_early_valid got %b want 0", bus.bridge_rd_valid); end
        step();
        total++; if ({bus.bridge_rd_valid, bus.bridge_ready} !== 2'b11) begin bad++; $display("FAIL rd_n5 vld/rdy got %b want 11", {bus.bridge_rd_valid, bus.bridge_ready}); end
        total++; if (bus.bridge_rd_data !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got %h want DEADBEEF", bus.bridge_rd_data); end
        step();
        total++; if (bus.bridge_rd_valid !== 1'b0) begin bad++; $display("FAIL rd_valid_width got %b want 0", bus.bridge_rd_valid); end
    endtask

    task automatic test_core();
        int acks = 0;
        bus.core_req = 1'b1; bus.core_addr = 16'h0081;
        step();
        total++; if ({bus.sram_a, bus.sram_oe_n, bus.sram_we_n} !== {16'h0081, 2'b01}) begin bad++; $display("FAIL core_grant got %h/%b want 0081/01", bus.sram_a, {bus.sram_oe_n, bus.sram_we_n}); end
        step();
        total++; if (bus.core_ack !== 1'b0) begin bad++; $display("FAIL core_early_ack got %b want 0", bus.core_ack); end
        step();
        total++; if (bus.core_ack !== 1'b1) begin bad++; $display("FAIL core_ack_m2 got %b want 1", bus.core_ack); end
        total++; if (bus.core_rd_data !== 16'hBEEF) begin bad++; $display("FAIL core_data got %h want BEEF", bus.core_rd_data); end
        bus.core_req = 1'b0;
        for (int i = 0; i < 4; i++) begin step(); if (bus.core_ack) acks++; end
        total++; if (acks != 0) begin bad++; $display("FAIL core_single_pulse extra acks %0d want 0", acks); end
    endtask

    task automatic test_drop();
        int vld = 0;
        bridge_pulse(1'b1, 1'b0, 32'h300, 32'hA5A5A5A5);
        wait_idle("drop_pre");
        total++; if (bus.err_drop !== 1'b0) begin bad++; $display("FAIL drop_pre_err got %b want 0", bus.err_drop); end
        bus.bridge_wr = 1'b1; bus.bridge_rd = 1'b1; bus.bridge_addr = 32'h200; bus.bridge_wr_data = 32'h11223344;
        step();
        total++; if (bus.err_drop !== 1'b1) begin bad++; $display("FAIL drop_simul_err got %b want 1", bus.err_drop); end
        bus.bridge_rd = 1'b0; bus.bridge_addr = 32'h300; bus.bridge_wr_data = 32'h55667788;
        step();
        bus.bridge_wr = 1'b0;
        for (int i = 0; i < 12; i++) begin step(); if (bus.bridge_rd_valid) vld++; end
        wait_idle("drop_post");
        total++; if (vld != 0) begin bad++; $display("FAIL drop_no_read got %0d valids want 0", vld); end
        total++; if ({mem[16'h100], mem[16'h101]} !== 32'h11223344) begin bad++; $display("FAIL drop_kept_wr got %h want 11223344", {mem[16'h100], mem[16'h101]}); end
        total++; if ({mem[16'h180], mem[16'h181]} !== 32'hA5A5A5A5) begin bad++; $display("FAIL drop_busy_wr got %h want A5A5A5A5", {mem[16'h180], mem[16'h181]}); end
        total++; if (bus.err_drop !== 1'b1) begin bad++; $display("FAIL drop_sticky got %b want 1", bus.err_drop); end
    endtask

    task automatic test_arbitration();
        logic [15:0] exp6, exp9, exp11;
`ifdef SRAM_ARB_FAIR_EN
        exp6 = 16'h0010; exp9 = 16'h0280; exp11 = 16'h0281;
`else
        exp6 = 16'h0280; exp9 = 16'h0281; exp11 = 16'h0010;
`endif
        bus.core_addr = 16'h0010;
        bridge_pulse(1'b1, 1'b0, 32'h400, 32'h01020304);
        bus.core_req = 1'b1;
        step(); step(); step(); step();
        total++; if (bus.bridge_ready !== 1'b1) begin bad++; $display("FAIL arb_ready_n5 got %b want 1", bus.bridge_ready); end
        bridge_pulse(1'b1, 1'b0, 32'h500, 32'h0A0B0C0D);
        total++; if (bus.sram_a !== exp6) begin bad++; $display("FAIL arb_n6 sram_a got %h want %h", bus.sram_a, exp6); end
        step(); step(); step();
        total++; if (bus.sram_a !== exp9) begin bad++; $display("FAIL arb_n9 sram_a got %h want %h", bus.sram_a, exp9); end
        step(); step();
        total++; if (bus.sram_a !== exp11) begin bad++; $display("FAIL arb_n11 sram_a got %h want %h", bus.sram_a, exp11); end
        bus.core_req = 1'b0;
        wait_idle("arb_end");
        total++; if ({mem[16'h280], mem[16'h281]} !== 32'h0A0B0C0D) begin bad++; $display("FAIL arb_mem got %h want 0A0B0C0D", {mem[16'h280], mem[16'h281]}); end
    endtask

    task automatic test_reset_mid();
        int vld = 0;
        bridge_pulse(1'b0, 1'b1, 32'h100, 32'h0);
        step(); step();
        total++; if ({bus.sram_a, bus.sram_oe_n} !== {16'h0081, 1'b0}) begin bad++; $display("FAIL rmid_in_lo got %h/%b want 0081/0", bus.sram_a, bus.sram_oe_n); end
        #2 rst_n = 1'b0;
        #1;
        total++; if ({bus.sram_oe_n, bus.sram_ub_n, bus.bridge_ready, bus.err_drop} !== 4'b1110) begin bad++; $display("FAIL rmid_async got %b want 1110", {bus.sram_oe_n, bus.sram_ub_n, bus.bridge_ready, bus.err_drop}); end
        total++; if (bus.sram_a !== 16'h0) begin bad++; $display("FAIL rmid_addr got %h want 0000", bus.sram_a); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin step(); if (bus.bridge_rd_valid || bus.core_ack) vld++; end
        total++; if (vld != 0) begin bad++; $display("FAIL rmid_no_valid got %0d pulses want 0", vld); end
        bridge_pulse(1'b0, 1'b1, 32'h100, 32'h0);
        step(); step(); step(); step();
        total++; if ({bus.bridge_rd_valid, bus.bridge_rd_data} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL rmid_next_cmd got %b/%h want 1/DEADBEEF", bus.bridge_rd_valid, bus.bridge_rd_data); end
    endtask

    initial begin
        bus.bridge_addr = '0; bus.bridge_wr = 1'b0; bus.bridge_wr_data = '0; bus.bridge_rd = 1'b0;
        bus.core_req = 1'b0; bus.core_addr = '0;
        test_reset();
        test_write();
        test_read();
        test_core();
        test_drop();
        test_arbitration();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
